// File: rtl/tone_period_encoder_if.sv
// Tone input and recognition results exchanged between the encoder and its user.
interface tone_period_encoder_if;
  logic       tone_in;
  logic [3:0] tone;
  logic       tone_valid;
  logic       new_tone;
  logic       no_tone;
  logic [9:0] meas_value;

  // master drives the tone and consumes results; slave is the encoder
  modport master (output tone_in, input tone, tone_valid, new_tone, no_tone, meas_value);
  modport slave  (input tone_in, output tone, tone_valid, new_tone, no_tone, meas_value);
endinterface

// File: rtl/tone_period_encoder.sv
// Measures the half-period of a square-wave tone in prescaler ticks, finds the
// nearest entry in the 16-entry tone prescale table with a sequential search,
// and publishes the tone index once it has been seen on enough consecutive halves.
module tone_period_encoder #(
  parameter int TICK_DIV  = 64,
  parameter int TOL       = 6,
  parameter int MATCH_CNT = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 resetN,
  tone_period_encoder_if.slave bus
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Element 0 is the rightmost entry.
  localparam logic [15:0][9:0] TONE_TABLE = {
    10'h1BB, 10'h18B, 10'h175, 10'h14C, 10'h128, 10'h117, 10'h0F9, 10'h0DD,
    10'h2EA, 10'h2C0, 10'h299, 10'h273, 10'h250, 10'h22F, 10'h20F, 10'h1F2};

  typedef enum logic [1:0] {ARM, MEASURE, SEARCH} state_e;

  typedef struct packed {
    logic [10:0] diff;
    logic [3:0]  idx;
  } best_t;

  logic             sync1_q, sync2_q, prev_q, edge_q;
  logic [DIV_W-1:0] div_q;
  logic [9:0]       hp_q, hp_d, meas_q;
  logic             tick, tmo;

  state_e      state_q;
  logic [3:0]  idx_q;
  best_t       best_q, best_d;
  logic        drop_q;
  logic [3:0]  cand_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  tone_q;
  logic        valid_q, new_q, no_tone_q;
  logic [10:0] entry, meas_ext, diff;
  logic        hit;

  // Two-flop synchroniser, then a registered both-edge detector.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= bus.tone_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q ^ prev_q;
    end
  end

  assign tick = (div_q == DIV_W'(TICK_DIV - 1));
  assign hp_d = (tick && hp_q != 10'h3FF) ? hp_q + 10'd1 : hp_q;
  // Fires on the single tick where hp arrives at TIMEOUT; saturation keeps it one-shot.
  assign tmo  = tick && (hp_q == 10'(TIMEOUT - 1));

  // Tick divider and half-period counter, both restarted by every edge. A tick
  // coinciding with the edge is included in the captured value.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      div_q  <= '0;
      hp_q   <= '0;
      meas_q <= '0;
    end else if (edge_q) begin
      div_q  <= '0;
      hp_q   <= '0;
      meas_q <= hp_d;
    end else begin
      div_q  <= tick ? '0 : div_q + DIV_W'(1);
      hp_q   <= hp_d;
    end
  end

  // One table entry per SEARCH cycle; strict compare keeps the lower index on ties.
  always_comb begin
    entry    = {1'b0, TONE_TABLE[idx_q]};
    meas_ext = {1'b0, meas_q};
    diff     = (meas_ext >= entry) ? meas_ext - entry : entry - meas_ext;
    best_d   = best_q;
    if (idx_q == 4'd0 || diff < best_q.diff) begin
      best_d.diff = diff;
      best_d.idx  = idx_q;
    end
    hit   = (best_d.diff <= 11'(TOL));
    cnt_d = 3'd1;
    if (best_d.idx == cand_q)
      cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
  end

  // Control FSM with registered results; evaluation happens on the 16th search cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ARM;
      idx_q     <= '0;
      best_q    <= '0;
      drop_q    <= 1'b0;
      cand_q    <= '0;
      cnt_q     <= '0;
      tone_q    <= '0;
      valid_q   <= 1'b0;
      new_q     <= 1'b0;
      no_tone_q <= 1'b1;
    end else begin
      new_q <= 1'b0;
      case (state_q)
        ARM: begin
          if (edge_q) begin
            state_q <= MEASURE;
          end else if (tmo) begin
            valid_q   <= 1'b0;
            no_tone_q <= 1'b1;
            cnt_q     <= '0;
          end
        end
        MEASURE: begin
          if (edge_q) begin
            state_q <= SEARCH;
            idx_q   <= '0;
            drop_q  <= 1'b0;
          end else if (tmo) begin
            valid_q   <= 1'b0;
            no_tone_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ARM;
          end
        end
        SEARCH: begin
          best_q <= best_d;
          idx_q  <= idx_q + 4'd1;
          // An edge mid-search invalidates the running result and the streak.
          if (edge_q) begin
            drop_q <= 1'b1;
            cnt_q  <= '0;
          end
          if (idx_q == 4'd15) begin
            state_q <= MEASURE;
            if (drop_q || edge_q) begin
              cnt_q <= '0;
            end else if (hit) begin
              cand_q <= best_d.idx;
              cnt_q  <= cnt_d;
              if (cnt_d >= 3'(MATCH_CNT)) begin
                tone_q    <= best_d.idx;
                valid_q   <= 1'b1;
                no_tone_q <= 1'b0;
                new_q     <= !valid_q || (tone_q != best_d.idx);
              end
            end else begin
              cnt_q     <= '0;
              valid_q   <= 1'b0;
              no_tone_q <= 1'b1;
            end
          end
        end
        default: state_q <= ARM;
      endcase
    end
  end

  assign bus.tone       = tone_q;
  assign bus.tone_valid = valid_q;
  assign bus.new_tone   = new_q;
  assign bus.no_tone    = no_tone_q;
  assign bus.meas_value = meas_q;
endmodule

// File: tb/tb_tone_period_encoder.sv
// Bench for tone_period_encoder: directed scenarios with literal pins plus
// randomized half-periods, all outputs compared every cycle against a model.
module tb_tone_period_encoder;
  localparam int TD      = 4;
  localparam int TOL     = 6;
  localparam int MCNT    = 2;
  localparam int TIMEOUT = 1023;
  localparam int TBL [16] = '{'h1F2, 'h20F, 'h22F, 'h250, 'h273, 'h299, 'h2C0, 'h2EA,
                              'h0DD, 'h0F9, 'h117, 'h128, 'h14C, 'h175, 'h18B, 'h1BB};

  logic clk = 1'b0;
  logic resetN = 1'b0;
  tone_period_encoder_if tif();

  tone_period_encoder #(.TICK_DIV(TD), .TOL(TOL), .MATCH_CNT(MCNT), .TIMEOUT(TIMEOUT))
    dut (.clk(clk), .resetN(resetN), .bus(tif));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ld = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Edges are known by the cycle at which the encoder acts on them (drive + 4).
  int eq[$];
  int last, mode, srch_end, pbi, pbd, cand, cnt, m_tone, m_meas;
  bit drop, m_valid, m_new, m_no;

  task automatic mreset();
    last = cyc; mode = 0; srch_end = 0; drop = 0; cand = 0; cnt = 0;
    m_tone = 0; m_valid = 0; m_new = 0; m_no = 1; m_meas = 0;
    eq.delete();
  endtask

  function automatic int cap_val(input int t);
    int v = (t - last) / TD;
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic nearest(input int m);
    pbd = 100000; pbi = 0;
    for (int i = 0; i < 16; i++) begin
      int d = m - TBL[i];
      if (d < 0) d = -d;
      if (d < pbd) begin pbd = d; pbi = i; end
    end
  endtask

  task automatic evaluate();
    if (drop) cnt = 0;
    else if (pbd <= TOL) begin
      if (pbi == cand) cnt = (cnt < 7) ? cnt + 1 : 7;
      else begin cand = pbi; cnt = 1; end
      if (cnt >= MCNT) begin
        m_new = !m_valid || (m_tone != pbi);
        m_tone = pbi; m_valid = 1; m_no = 0;
      end
    end else begin
      cnt = 0; m_valid = 0; m_no = 1;
    end
  endtask

  task automatic mstep(input int t);
    bit e = (eq.size() > 0 && eq[0] == t);
    if (e) void'(eq.pop_front());
    m_new = 0;
    if (mode == 2 && t == srch_end) begin
      if (e) begin m_meas = cap_val(t); last = t; drop = 1; end
      evaluate();
      mode = 1;
    end else if (mode == 2 && e) begin
      m_meas = cap_val(t); last = t; drop = 1; cnt = 0;
    end else if (e) begin
      m_meas = cap_val(t); last = t;
      if (mode == 0) mode = 1;
      else begin nearest(m_meas); mode = 2; srch_end = t + 16; drop = 0; end
    end else if (mode != 2 && (t - last) == TIMEOUT * TD) begin
      m_valid = 0; m_no = 1; cnt = 0; mode = 0;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!resetN) mreset();
    else mstep(cyc);
  end

  always @(negedge resetN) mreset();

  // Compare every output every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("tone", int'(tif.tone), m_tone);
      check("tone_valid", int'(tif.tone_valid), int'(m_valid));
      check("new_tone", int'(tif.new_tone), int'(m_new));
      check("no_tone", int'(tif.no_tone), int'(m_no));
      check("meas_value", int'(tif.meas_value), m_meas);
    end
  end

  // ---------------- stimulus ----------------
  // Toggle tone_in n cycles after the previous toggle.
  task automatic half(input int n);
    while (cyc < ld + n) begin @(posedge clk); #1; end
    tif.tone_in = ~tif.tone_in;
    ld = cyc;
    if (resetN) eq.push_back(cyc + 4);
  endtask

  task automatic wait_to(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cap;
    tif.tone_in = 1'b0;
    resetN = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_tone", int'(tif.tone), 0);
    check("rst_valid", int'(tif.tone_valid), 0);
    check("rst_no_tone", int'(tif.no_tone), 1);
    check("rst_meas", int'(tif.meas_value), 0);
    resetN = 1'b1;
    ld = cyc;

    // Lock on tone 15
    half(10);
    half('h1BB * TD);
    half('h1BB * TD);
    cap = ld;
    wait_to(cap + 19);
    check("lock15_early", int'(tif.new_tone), 0);
    wait_to(cap + 20);
    check("lock15_pulse", int'(tif.new_tone), 1);
    check("lock15_tone", int'(tif.tone), 15);
    check("lock15_valid", int'(tif.tone_valid), 1);
    check("lock15_meas", int'(tif.meas_value), 'h1BB);
    half('h1BB * TD);
    half('h1BB * TD);

    // Change to tone 8, then just outside tolerance
    half(('h0DD + 5) * TD);
    half(('h0DD + 5) * TD);
    wait_to(ld + 20);
    check("tone8", int'(tif.tone), 8);
    check("tone8_pulse", int'(tif.new_tone), 1);
    half(('h0DD + 7) * TD);
    wait_to(ld + 20);
    check("miss_valid", int'(tif.tone_valid), 0);
    check("miss_no_tone", int'(tif.no_tone), 1);
    check("miss_tone_held", int'(tif.tone), 8);

    // Nearest entry, then an equidistant miss
    half('h1F5 * TD);
    half('h1F5 * TD);
    wait_to(ld + 20);
    check("tone0", int'(tif.tone), 0);
    check("tone0_valid", int'(tif.tone_valid), 1);
    half('h180 * TD);
    wait_to(ld + 20);
    check("tie_miss", int'(tif.tone_valid), 0);

    // Lock tone 13 then go silent
    half('h175 * TD);
    half('h175 * TD);
    wait_to(ld + 20);
    check("tone13", int'(tif.tone), 13);
    cap = ld;
    wait_to(cap + 4 + TIMEOUT * TD - 1);
    check("pre_timeout", int'(tif.tone_valid), 1);
    wait_to(cap + 4 + TIMEOUT * TD);
    check("timeout_valid", int'(tif.tone_valid), 0);
    check("timeout_no_tone", int'(tif.no_tone), 1);

    // Restart: arm edge plus two halves
    @(posedge clk); #1;
    ld = cyc;
    half(3);
    half('h175 * TD);
    wait_to(ld + 20);
    check("rearm_one_half", int'(tif.tone_valid), 0);
    half('h175 * TD);
    wait_to(ld + 20);
    check("relock_pulse", int'(tif.new_tone), 1);
    check("relock_tone", int'(tif.tone), 13);

    // Glitch during search
    half('h175 * TD);
    cap = ld;
    half(5);
    wait_to(cap + 20);
    check("glitch_valid", int'(tif.tone_valid), 1);
    check("glitch_nopulse", int'(tif.new_tone), 0);
    half('h175 * TD - 5);
    half('h175 * TD);
    wait_to(ld + 20);
    check("post_glitch_valid", int'(tif.tone_valid), 1);

    // Reset mid-search
    half('h175 * TD);
    repeat (8) @(posedge clk);
    #1;
    resetN = 1'b0;
    #1;
    check("mid_rst_valid", int'(tif.tone_valid), 0);
    check("mid_rst_no_tone", int'(tif.no_tone), 1);
    check("mid_rst_tone", int'(tif.tone), 0);
    tif.tone_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;
    ld = cyc;
    half(10);

    // Randomized tones near table entries, occasional glitches
    for (int k = 0; k < 5; k++) begin
      int ti   = int'($urandom_range(0, 15));
      int reps = int'($urandom_range(1, 2));
      for (int r = 0; r < reps + 1; r++) begin
        int off = int'($urandom_range(0, 16)) - 8;
        half((TBL[ti] + off) * TD + int'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 3) == 0) half(int'($urandom_range(2, 14)));
    end
    wait_to(ld + 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
